// File: rtl/rcv_fifo_ctrl.sv
// Receive FIFO pointer/storage stage: packs bytes little-endian into 32-bit words
// held in a 4-entry memory and serves whole words first-word fall-through.
module rcv_fifo_ctrl (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        w_enable,
    input  logic [7:0]  w_data,
    input  logic        r_enable,
    input  logic        flush,
    input  logic        full,
    input  logic        empty,
    output logic [31:0] r_data,
    output logic [1:0]  head_ptr,
    output logic        head_tog,
    output logic [1:0]  tail_ptr,
    output logic        tail_tog,
    output logic [1:0]  tail_side,
    output logic        overrun,
    output logic        underrun
);

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned SIDE_W     = $clog2(WORD_BYTES);
    localparam int unsigned WORD_W     = 8 * WORD_BYTES;

    logic [WORD_W-1:0] mem [DEPTH];
    logic              word_avail;
    logic              wr_ok;
    logic              rd_ok;
    logic              unused_empty;

    // The empty flag also counts the partial tail word, so it cannot gate reads.
    assign unused_empty = empty;

    // Whole-word availability comes from our own pointers, never from a partial word.
    always_comb begin
        word_avail = !((head_ptr == tail_ptr) && (head_tog == tail_tog));
        wr_ok      = w_enable && !full;
        rd_ok      = r_enable && word_avail;
        r_data     = mem[head_ptr];
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            head_ptr  <= '0;
            head_tog  <= 1'b0;
            tail_ptr  <= '0;
            tail_tog  <= 1'b0;
            tail_side <= '0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else if (flush) begin
            // Memory contents are left alone; only the bookkeeping is cleared.
            head_ptr  <= '0;
            head_tog  <= 1'b0;
            tail_ptr  <= '0;
            tail_tog  <= 1'b0;
            tail_side <= '0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            overrun  <= w_enable && full;
            underrun <= r_enable && !word_avail;
            if (wr_ok) begin
                mem[tail_ptr][{tail_side, 3'b000} +: 8] <= w_data;
                tail_side <= tail_side + SIDE_W'(1);
                if (tail_side == SIDE_W'(WORD_BYTES - 1)) begin
                    tail_ptr <= tail_ptr + PTR_W'(1);
                    if (tail_ptr == PTR_W'(DEPTH - 1)) begin
                        tail_tog <= ~tail_tog;
                    end
                end
            end
            if (rd_ok) begin
                head_ptr <= head_ptr + PTR_W'(1);
                if (head_ptr == PTR_W'(DEPTH - 1)) begin
                    head_tog <= ~head_tog;
                end
            end
        end
    end

endmodule

// File: tb/tb_rcv_fifo_ctrl.sv
// Directed bench for rcv_fifo_ctrl; full/empty come from a small model of the
// downstream comb block built on the exported pointers.
module tb_rcv_fifo_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        w_enable;
    logic [7:0]  w_data;
    logic        r_enable;
    logic        flush;
    logic        full;
    logic        empty;
    logic [31:0] r_data;
    logic [1:0]  head_ptr;
    logic        head_tog;
    logic [1:0]  tail_ptr;
    logic        tail_tog;
    logic [1:0]  tail_side;
    logic        overrun;
    logic        underrun;

    int n_checks = 0;
    int n_pass   = 0;

    rcv_fifo_ctrl dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .w_enable  (w_enable),
        .w_data    (w_data),
        .r_enable  (r_enable),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .r_data    (r_data),
        .head_ptr  (head_ptr),
        .head_tog  (head_tog),
        .tail_ptr  (tail_ptr),
        .tail_tog  (tail_tog),
        .tail_side (tail_side),
        .overrun   (overrun),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    // Downstream flag block: four complete words is full, partial tail word is not empty.
    assign full  = (head_ptr == tail_ptr) && (head_tog != tail_tog);
    assign empty = (head_ptr == tail_ptr) && (head_tog == tail_tog) && (tail_side == 2'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        w_enable = 1'b1;
        w_data   = b;
        tick();
        w_enable = 1'b0;
    endtask

    logic [7:0]  bytes_q [40];
    logic [31:0] exp_word;
    int          wr_idx;
    int          rd_idx;
    int          cyc;
    int          htog_cnt;
    int          ttog_cnt;
    logic        prev_htog;
    logic        prev_ttog;
    logic        avail;

    initial begin
        n_rst = 1'b1; w_enable = 1'b0; w_data = 8'h00; r_enable = 1'b0; flush = 1'b0;

        // 1: reset state, one word, partial-word underrun
        do_reset();
        tick();
        chk("rst_head", 32'(head_ptr), 32'd0);
        chk("rst_tail", 32'(tail_ptr), 32'd0);
        chk("rst_side", 32'(tail_side), 32'd0);
        chk("rst_rdata", r_data, 32'h0);
        chk("rst_over", 32'(overrun), 32'd0);
        chk("rst_under", 32'(underrun), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
        chk("t1_side3", 32'(tail_side), 32'd3);
        chk("t1_empty3", 32'(empty), 32'd0);
        r_enable = 1'b1; tick(); r_enable = 1'b0;
        chk("t1_under", 32'(underrun), 32'd1);
        chk("t1_head_hold", 32'(head_ptr), 32'd0);
        tick();
        chk("t1_under_clr", 32'(underrun), 32'd0);
        write_byte(8'h44);
        chk("t1_tail", 32'(tail_ptr), 32'd1);
        chk("t1_side0", 32'(tail_side), 32'd0);
        chk("t1_empty", 32'(empty), 32'd0);
        chk("t1_rdata", r_data, 32'h44332211);

        // 2: fill to full, then overrun
        do_reset();
        for (int k = 0; k < 16; k++) write_byte(8'(k + 1));
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_tail", 32'(tail_ptr), 32'd0);
        chk("t2_ttog", 32'(tail_tog), 32'd1);
        chk("t2_rdata", r_data, 32'h04030201);
        write_byte(8'hEE);
        chk("t2_over", 32'(overrun), 32'd1);
        chk("t2_tail_hold", 32'(tail_ptr), 32'd0);
        chk("t2_side_hold", 32'(tail_side), 32'd0);
        chk("t2_ttog_hold", 32'(tail_tog), 32'd1);
        tick();
        chk("t2_over_clr", 32'(overrun), 32'd0);

        // 3: read+write while full: pop succeeds, write dropped
        r_enable = 1'b1; w_enable = 1'b1; w_data = 8'hAA;
        tick();
        r_enable = 1'b0; w_enable = 1'b0;
        chk("t3_head", 32'(head_ptr), 32'd1);
        chk("t3_side", 32'(tail_side), 32'd0);
        chk("t3_over", 32'(overrun), 32'd1);
        chk("t3_full", 32'(full), 32'd0);
        chk("t3_rdata", r_data, 32'h08070605);

        // 4: streaming 40 bytes in, 10 words out
        do_reset();
        for (int i = 0; i < 40; i++) bytes_q[i] = 8'(i * 7 + 3);
        wr_idx = 0; rd_idx = 0; cyc = 0; htog_cnt = 0; ttog_cnt = 0;
        prev_htog = head_tog; prev_ttog = tail_tog;
        while ((wr_idx < 40 || rd_idx < 10) && cyc < 200) begin
            avail    = !((head_ptr == tail_ptr) && (head_tog == tail_tog));
            w_enable = (wr_idx < 40);
            w_data   = (wr_idx < 40) ? bytes_q[wr_idx] : 8'h00;
            r_enable = avail;
            if (avail && rd_idx < 10) begin
                exp_word = {bytes_q[4*rd_idx+3], bytes_q[4*rd_idx+2],
                            bytes_q[4*rd_idx+1], bytes_q[4*rd_idx]};
                chk($sformatf("t4_word%0d", rd_idx), r_data, exp_word);
                rd_idx++;
            end
            if (wr_idx < 40) wr_idx++;
            tick();
            if (head_tog != prev_htog) htog_cnt++;
            if (tail_tog != prev_ttog) ttog_cnt++;
            prev_htog = head_tog; prev_ttog = tail_tog;
            cyc++;
        end
        w_enable = 1'b0; r_enable = 1'b0;
        chk("t4_reads", 32'(rd_idx), 32'd10);
        chk("t4_htog_cnt", 32'(htog_cnt), 32'd2);
        chk("t4_ttog_cnt", 32'(ttog_cnt), 32'd2);
        chk("t4_head", 32'(head_ptr), 32'd2);
        chk("t4_tail", 32'(tail_ptr), 32'd2);
        chk("t4_empty", 32'(empty), 32'd1);

        // 5: flush overrides a concurrent write
        do_reset();
        write_byte(8'hDE); write_byte(8'hAD);
        flush = 1'b1; w_enable = 1'b1; w_data = 8'hBE;
        tick();
        flush = 1'b0; w_enable = 1'b0;
        chk("t5_head", 32'(head_ptr), 32'd0);
        chk("t5_tail", 32'(tail_ptr), 32'd0);
        chk("t5_side", 32'(tail_side), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        write_byte(8'h01); write_byte(8'h02); write_byte(8'h03); write_byte(8'h04);
        chk("t5_rdata", r_data, 32'h04030201);
        chk("t5_tail_after", 32'(tail_ptr), 32'd1);

        // 6: reset mid-packet
        do_reset();
        for (int k = 0; k < 6; k++) write_byte(8'(8'h10 + k));
        chk("t6_pre_tail", 32'(tail_ptr), 32'd1);
        do_reset();
        chk("t6_tail", 32'(tail_ptr), 32'd0);
        chk("t6_side", 32'(tail_side), 32'd0);
        chk("t6_ttog", 32'(tail_tog), 32'd0);
        chk("t6_rdata", r_data, 32'h0);
        chk("t6_empty", 32'(empty), 32'd1);
        write_byte(8'h5A);
        chk("t6_side1", 32'(tail_side), 32'd1);
        chk("t6_tail_hold", 32'(tail_ptr), 32'd0);
        write_byte(8'h5B); write_byte(8'h5C); write_byte(8'h5D);
        chk("t6_rdata_new", r_data, 32'h5D5C5B5A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
